// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Priority encoding and reset defaults live here.
package rf_arb_pkg;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_t;

  localparam pri_t PRI_RESET  = PRI0;
  localparam int   CW_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic with its priority state.
// Priority only moves on contested cycles, to the losing side.
module rr_arbiter2
  import rf_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  pri_t r_pri;
  pri_t w_pri_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pri <= PRI_RESET;
    else       r_pri <= w_pri_nxt;
  end

  always_comb begin
    gnt       = 2'b00;
    w_pri_nxt = r_pri;
    if (enable) begin
      unique case (req)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          if (r_pri == PRI0) begin
            gnt       = 2'b01;
            w_pri_nxt = PRI1;
          end else begin
            gnt       = 2'b10;
            w_pri_nxt = PRI0;
          end
        end
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between execute and load writeback.
// The registered port doubles as a one-entry bypass of the in-flight write.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter  int Nloc  = 32,
  parameter  int Dbits = 32,
  parameter  int CW    = CW_DEFAULT,
  localparam int AW    = $clog2(Nloc)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [Dbits-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [Dbits-1:0] req1_data,
  output logic             req1_ready,
  output logic             rf_wr,
  output logic [AW-1:0]    rf_addr,
  output logic [Dbits-1:0] rf_data,
  output logic [CW-1:0]    conflict_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]       w_gnt;
  logic             w_xfer0;
  logic             w_xfer1;
  logic             w_xfer;
  logic             w_conflict;
  logic [AW-1:0]    w_addr;
  logic [Dbits-1:0] w_data;

  logic             r_wr;
  logic [AW-1:0]    r_addr;
  logic [Dbits-1:0] r_data;
  logic [CW-1:0]    r_cnt;

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .req    ({req1_valid, req0_valid}),
    .gnt    (w_gnt)
  );

  assign req0_ready = w_gnt[0] & ~reset;
  assign req1_ready = w_gnt[1] & ~reset;

  assign w_xfer0    = req0_valid & req0_ready;
  assign w_xfer1    = req1_valid & req1_ready;
  assign w_xfer     = w_xfer0 | w_xfer1;
  assign w_conflict = enable & req0_valid & req1_valid;
  assign w_addr     = w_xfer1 ? req1_addr : req0_addr;
  assign w_data     = w_xfer1 ? req1_data : req0_data;

  // x0 writes are swallowed here but still land on addr/data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      r_wr <= w_xfer && (w_addr != '0);
      if (w_xfer) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
      if (w_conflict && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign rf_wr          = r_wr;
  assign rf_addr        = r_addr;
  assign rf_data        = r_data;
  assign conflict_count = r_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter against a rule-level model.
// A second instance with a 4-bit counter exercises saturation.
module tb_rf_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [15:0] conflict_count;

  logic        s_r0;
  logic        s_r1;
  logic        s_wr;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_cnt;

  rf_write_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .rf_wr          (rf_wr),
    .rf_addr        (rf_addr),
    .rf_data        (rf_data),
    .conflict_count (conflict_count)
  );

  rf_write_arbiter #(.CW(4)) dut4 (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (s_r0),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (s_r1),
    .rf_wr          (s_wr),
    .rf_addr        (s_addr),
    .rf_data        (s_data),
    .conflict_count (s_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [15:0] c;
    logic [3:0]  c4;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  int          m_pri;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;
  int          m_cnt4;
  bit          g0;
  bit          g1;

  logic [31:0] rf_mem [32];

  always @(posedge clock)
    if (rf_wr) rf_mem[rf_addr] = rf_data;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pri  = 0;
    m_wr   = 0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = 0;
    m_cnt4 = 0;
  endtask

  // one bus cycle: predict grants, check readies, then advance the model
  task automatic step();
    bool_grants();
    chk("req0_ready", 64'(req0_ready), 64'(g0));
    chk("req1_ready", 64'(req1_ready), 64'(g1));
    @(posedge clock);
    if (enable && req0_valid && req1_valid) begin
      m_pri = g0 ? 1 : 0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (g0 || g1) begin
      m_addr = g0 ? req0_addr : req1_addr;
      m_data = g0 ? req0_data : req1_data;
      m_wr   = (m_addr != 0);
    end else begin
      m_wr = 0;
    end
    q.push_back({m_wr, m_addr, m_data, m_cnt[15:0], m_cnt4[3:0]});
    #1;
  endtask

  task automatic bool_grants();
    @(negedge clock);
    g0 = 0;
    g1 = 0;
    if (enable) begin
      if (req0_valid && req1_valid) begin
        g0 = (m_pri == 0);
        g1 = !g0;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
  endtask

  task automatic refresh(input bit force_v);
    if (g0 || !req0_valid) begin
      req0_valid = force_v || ($urandom_range(0, 3) != 0);
      req0_addr  = 5'($urandom_range(0, 31));
      req0_data  = $urandom;
    end
    if (g1 || !req1_valid) begin
      req1_valid = force_v || ($urandom_range(0, 3) != 0);
      req1_addr  = 5'($urandom_range(0, 31));
      req1_data  = $urandom;
    end
  endtask

  task automatic drain();
    enable = 1'b1;
    repeat (3) begin
      step();
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
    end
  endtask

  // monitor: per-cycle scoreboard plus requester hold rule
  logic        p_v0, p_r0, p_v1, p_r1, p_rst;
  logic [4:0]  p_a0, p_a1;
  logic [31:0] p_d0, p_d1;
  exp_t        e;

  initial begin
    p_rst = 1'b1;
    p_v0  = 1'b0;
    p_v1  = 1'b0;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rf_wr", 64'(rf_wr), 64'(e.wr));
        chk("rf_addr", 64'(rf_addr), 64'(e.a));
        chk("rf_data", 64'(rf_data), 64'(e.d));
        chk("conflict_count", 64'(conflict_count), 64'(e.c));
        chk("count_cw4", 64'(s_cnt), 64'(e.c4));
      end
      if (!reset && !p_rst && p_v0 && !p_r0)
        chk("req0_hold", {26'd0, req0_valid, req0_addr, req0_data},
            {26'd0, 1'b1, p_a0, p_d0});
      if (!reset && !p_rst && p_v1 && !p_r1)
        chk("req1_hold", {26'd0, req1_valid, req1_addr, req1_data},
            {26'd0, 1'b1, p_a1, p_d1});
      p_rst = reset;
      p_v0  = req0_valid;
      p_r0  = req0_ready;
      p_a0  = req0_addr;
      p_d0  = req0_data;
      p_v1  = req1_valid;
      p_r1  = req1_ready;
      p_a1  = req1_addr;
      p_d1  = req1_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    req0_valid = 1'b1;
    req0_addr  = 5'd1;
    req0_data  = 32'h1;
    req1_valid = 1'b1;
    req1_addr  = 5'd2;
    req1_data  = 32'h2;
    model_reset();
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    #2;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_rf_wr", 64'(rf_wr), 64'd0);
    chk("rst_rf_addr", 64'(rf_addr), 64'd0);
    chk("rst_rf_data", 64'(rf_data), 64'd0);
    chk("rst_count", 64'(conflict_count), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // single requester
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req0_data  = 32'hDEADBEEF;
    step();
    req0_valid = 1'b0;
    step();
    step();

    // contested rotation, distinct addresses
    req0_valid = 1'b1;
    req0_addr  = 5'd3;
    req0_data  = 32'h3333;
    req1_valid = 1'b1;
    req1_addr  = 5'd7;
    req1_data  = 32'h7777;
    repeat (4) step();
    chk("rotation_count", 64'(conflict_count), 64'd4);
    req1_valid = 1'b0;
    step();
    chk("rotation_drain_g0", 64'(g0), 64'd1);
    req0_valid = 1'b0;

    // same destination from PRI0
    req0_valid = 1'b1;
    req0_addr  = 5'd9;
    req0_data  = 32'h11;
    req1_valid = 1'b1;
    req1_addr  = 5'd9;
    req1_data  = 32'h22;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;
    step();
    step();
    chk("rf9_final", 64'(rf_mem[9]), 64'h22);

    // register 0 is accepted but never written
    req1_valid = 1'b1;
    req1_addr  = 5'd0;
    req1_data  = 32'hBAD0;
    step();
    req1_valid = 1'b0;
    step();

    // stall with both pending
    enable     = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 5'd4;
    req0_data  = 32'h4444;
    req1_valid = 1'b1;
    req1_addr  = 5'd6;
    req1_data  = 32'h6666;
    repeat (3) step();
    drain();

    // saturation of the 4-bit counter
    g0 = 1;
    g1 = 1;
    refresh(1'b1);
    repeat (20) begin
      step();
      refresh(1'b1);
    end
    chk("sat_cw4", 64'(s_cnt), 64'd15);
    drain();

    // randomized traffic
    repeat (400) begin
      enable = ($urandom_range(0, 6) != 0);
      step();
      refresh(1'b0);
    end
    drain();

    // reset while a write is in flight
    req0_valid = 1'b1;
    req0_addr  = 5'd12;
    req0_data  = 32'hCAFEF00D;
    step();
    req0_valid = 1'b0;
    chk("pre_rst_wr", 64'(rf_wr), 64'd1);
    #3;
    reset = 1'b1;
    q.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_rst_wr", 64'(rf_wr), 64'd0);
    chk("mid_rst_addr", 64'(rf_addr), 64'd0);
    chk("mid_rst_data", 64'(rf_data), 64'd0);
    chk("mid_rst_count", 64'(conflict_count), 64'd0);
    chk("mid_rst_ready0", 64'(req0_ready), 64'd0);
    chk("mid_rst_ready1", 64'(req1_ready), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    step();
    chk("post_rst_pri0", 64'(g0), 64'd1);
    req0_valid = 1'b0;
    drain();

    step();
    #6;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
